// File: rtl/bcd_result_sequencer.sv
// rtl/bcd_result_sequencer.sv - selects a binary result and converts it to saturating BCD by shift-add-3
// Optional macro BCD_SIGNED_EN: two's complement operands, magnitude converted and sign reported on neg.
module bcd_result_sequencer #(
  parameter int BIN_W   = 14,
  parameter int DIGITS  = 4,
  parameter int NUM_SRC = 2,
  localparam int SEL_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_SRC*BIN_W-1:0] src_bus,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic                     is_res,
  output logic                     busy,
  output logic                     done,
  output logic [4*DIGITS-1:0]      result_bcd,
  output logic [4*DIGITS-1:0]      disp_bcd,
  output logic                     overflow,
  output logic                     neg
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, next_state;
  logic [BIN_W-1:0]   bin_sr;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_sticky;
  logic [BIN_W-1:0]   op;
  logic [BIN_W-1:0]   mag;
  logic [ACC_W-1:0]   adj;
  logic [ACC_W-1:0]   acc_next;
  logic               ovf_next;
  logic               load;
  logic               last_shift;

  // Out-of-range selects fall through to source 0.
  always_comb begin
    op = src_bus[BIN_W-1:0];
    for (int i = 1; i < NUM_SRC; i++) begin
      if (src_sel == SEL_W'(i)) op = src_bus[i*BIN_W +: BIN_W];
    end
  end

`ifdef BCD_SIGNED_EN
  logic sign_pend;
  // The most negative operand wraps to 2^(BIN_W-1), which is its correct unsigned magnitude.
  assign mag = op[BIN_W-1] ? (~op + BIN_W'(1)) : op;
`else
  assign mag = op;
  assign neg = 1'b0;
`endif

  always_comb begin
    adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  // A bit leaving the top digit means the value no longer fits in DIGITS digits.
  assign acc_next   = {adj[ACC_W-2:0], bin_sr[BIN_W-1]};
  assign ovf_next   = ovf_sticky | adj[ACC_W-1];
  assign load       = start && (state != SHIFT);
  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = start ? SHIFT : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr     <= '0;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      result_bcd <= '0;
      overflow   <= 1'b0;
    end else if (load) begin
      bin_sr     <= mag;
      acc        <= '0;
      cnt        <= CNT_W'(BIN_W);
      ovf_sticky <= 1'b0;
    end else if (state == SHIFT) begin
      bin_sr     <= {bin_sr[BIN_W-2:0], 1'b0};
      acc        <= acc_next;
      cnt        <= cnt - CNT_W'(1);
      ovf_sticky <= ovf_next;
      // Publish on the final shift so the result is already valid in the DONE cycle.
      if (last_shift) begin
        result_bcd <= ovf_next ? {DIGITS{4'h9}} : acc_next;
        overflow   <= ovf_next;
      end
    end
  end

`ifdef BCD_SIGNED_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_pend <= 1'b0;
      neg       <= 1'b0;
    end else begin
      if (load)       sign_pend <= op[BIN_W-1];
      if (last_shift) neg       <= sign_pend;
    end
  end
`endif

  assign disp_bcd = is_res ? result_bcd : '0;

endmodule
